// File: rtl/echo_portal_pkg.sv
// Purpose: shared types and constants for the Echo portal request path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: method numbers, per-method payload sizes, the assembled request
// entry {kind, a, b}, and the request assembler state enum.
package echo_portal_pkg;

  localparam logic [15:0] METHOD_SAY  = 16'd0;
  localparam logic [15:0] METHOD_SAY2 = 16'd1;

  localparam logic [15:0] SAY_BITS  = 16'd32;
  localparam logic [15:0] SAY2_BITS = 16'd64;

  typedef enum logic {
    KIND_SAY  = 1'b0,
    KIND_SAY2 = 1'b1
  } req_kind_t;

  // One assembled request; b is zero for say.
  typedef struct packed {
    req_kind_t   kind;
    logic [31:0] a;
    logic [31:0] b;
  } req_entry_t;

  typedef enum logic {
    ASM_IDLE   = 1'b0,
    ASM_WAIT_B = 1'b1
  } asm_state_t;

  // Payload size in bits of a request method; 0 for unknown methods.
  function automatic logic [15:0] method_size_bits(input logic [15:0] method);
    logic [15:0] size;
    case (method)
      METHOD_SAY:  size = SAY_BITS;
      METHOD_SAY2: size = SAY2_BITS;
      default:     size = 16'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/echo_request_input_if.sv
// Purpose: bundle of host-side enqueue, size-query and core-side dispatch
// signals of the Echo request path.
// Latency/backpressure: n/a (wiring only).
// Modports: master = host/core environment, slave = echo_request_input.
interface echo_request_input_if;

  logic        RDY_requests_enq;
  logic        EN_requests_enq;
  logic [15:0] requests_enq_methodNumber;
  logic [31:0] requests_enq_v;

  logic        RDY_messageSize_size;
  logic [15:0] messageSize_size_methodNumber;
  logic [15:0] messageSize_size;

  logic        say__ENA;
  logic [31:0] say_v;
  logic        say__RDY;

  logic        say2__ENA;
  logic [31:0] say2_a;
  logic [31:0] say2_b;
  logic        say2__RDY;

  logic [15:0] err_count;

  modport master (
    input  RDY_requests_enq,
    output EN_requests_enq, requests_enq_methodNumber, requests_enq_v,
    input  RDY_messageSize_size, messageSize_size,
    output messageSize_size_methodNumber,
    input  say__ENA, say_v, say2__ENA, say2_a, say2_b,
    output say__RDY, say2__RDY,
    input  err_count
  );

  modport slave (
    output RDY_requests_enq,
    input  EN_requests_enq, requests_enq_methodNumber, requests_enq_v,
    output RDY_messageSize_size, messageSize_size,
    input  messageSize_size_methodNumber,
    output say__ENA, say_v, say2__ENA, say2_a, say2_b,
    input  say__RDY, say2__RDY,
    output err_count
  );

endinterface

// File: rtl/echo_req_fifo.sv
// Purpose: generic DEPTH x W synchronous FIFO, head visible combinationally.
// Latency: a pushed entry is visible at rdata_o the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty.
// Ports: clk/rst (async active-high), push_i/wdata_i, pop_i/rdata_o,
// full_o/empty_o.
module echo_req_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         wr_en, rd_en;

  // Extra MSB on each pointer separates full (wrapped) from empty.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign wr_en = push_i && !full_o;
  assign rd_en = pop_i && !empty_o;

  assign wptr_d  = wr_en ? wptr_q + 1'b1 : wptr_q;
  assign rptr_d  = rd_en ? rptr_q + 1'b1 : rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: contents are only observed through the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/echo_request_input.sv
// Purpose: assembles host request words into say/say2 messages, buffers them
//          and dispatches them in order to the Echo core.
// Latency: say dispatch the cycle after its word; say2 the cycle after its b word.
// Backpressure: RDY_requests_enq drops while the FIFO is full; a head whose
//               core RDY is low stalls all later entries.
// Ports: CLK, RST (async active-high), bus (echo_request_input_if.slave).
// Optional: ECHO_REQ_STATS_EN adds dispatch_count (wrapping count of dispatches).
module echo_request_input
  import echo_portal_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                CLK,
  input  logic                RST,
  echo_request_input_if.slave bus
`ifdef ECHO_REQ_STATS_EN
  ,
  output logic [31:0]         dispatch_count
`endif
);

  localparam int W = $bits(req_entry_t);

  asm_state_t  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [15:0] err_q, err_d;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  logic        rdy_enq;
  logic        accept;
  logic        take_new;
  logic        push;
  req_entry_t  push_entry;
  req_entry_t  head;
  logic        fifo_full, fifo_empty;
  logic        say_ena, say2_ena, pop;

  logic [15:0] method;
  logic [31:0] word;

  assign method  = bus.requests_enq_methodNumber;
  assign word    = bus.requests_enq_v;
  assign rdy_enq = !RST && !fifo_full;
  assign accept  = bus.EN_requests_enq && rdy_enq;

  // Assembler next state. A non-say2 word arriving in WAIT_B aborts the
  // partial say2 and is then handled as a fresh word (take_new), so an
  // invalid word there costs two error counts in one cycle.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    push       = 1'b0;
    push_entry = '0;
    err_inc    = 2'd0;
    take_new   = 1'b0;

    if (accept) begin
      if (state_q == ASM_WAIT_B) begin
        if (method == METHOD_SAY2) begin
          push       = 1'b1;
          push_entry = '{kind: KIND_SAY2, a: a_q, b: word};
          state_d    = ASM_IDLE;
        end else begin
          err_inc  = 2'd1;
          take_new = 1'b1;
        end
      end else begin
        take_new = 1'b1;
      end
    end

    if (take_new) begin
      state_d = ASM_IDLE;
      case (method)
        METHOD_SAY: begin
          push       = 1'b1;
          push_entry = '{kind: KIND_SAY, a: word, b: 32'd0};
        end
        METHOD_SAY2: begin
          a_d     = word;
          state_d = ASM_WAIT_B;
        end
        default: err_inc = err_inc + 2'd1;
      endcase
    end
  end

  assign err_sum = {1'b0, err_q} + {15'd0, err_inc};
  assign err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ASM_IDLE;
      a_q     <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      err_q   <= err_d;
    end
  end

  echo_req_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // RST gating makes the enables fall asynchronously with reset.
  assign say_ena  = !RST && !fifo_empty && (head.kind == KIND_SAY)  && bus.say__RDY;
  assign say2_ena = !RST && !fifo_empty && (head.kind == KIND_SAY2) && bus.say2__RDY;
  assign pop      = say_ena || say2_ena;

  assign bus.RDY_requests_enq     = rdy_enq;
  assign bus.RDY_messageSize_size = !RST;
  assign bus.messageSize_size     = RST ? 16'd0 : method_size_bits(bus.messageSize_size_methodNumber);
  assign bus.say__ENA             = say_ena;
  assign bus.say_v                = head.a;
  assign bus.say2__ENA            = say2_ena;
  assign bus.say2_a               = head.a;
  assign bus.say2_b               = head.b;
  assign bus.err_count            = err_q;

`ifdef ECHO_REQ_STATS_EN
  logic [31:0] disp_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) disp_q <= '0;
    else if (pop) disp_q <= disp_q + 32'd1;
  end

  assign dispatch_count = disp_q;
`endif

endmodule

// File: tb/tb_echo_request_input.sv
module tb_echo_request_input;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  echo_request_input_if bus();

`ifdef ECHO_REQ_STATS_EN
  logic [31:0] dispatch_count;
`endif

  echo_request_input #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef ECHO_REQ_STATS_EN
    ,
    .dispatch_count (dispatch_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Message-level reference: queue of complete messages awaiting dispatch,
  // a pending say2 first argument, and an error tally.
  typedef struct {
    bit        kind;
    bit [31:0] a;
    bit [31:0] b;
  } msg_t;

  msg_t      mq[$];
  bit        m_pend;
  bit [31:0] m_a;
  int        m_err;
  int        m_disp;

  task automatic model_reset();
    mq.delete();
    m_pend = 0;
    m_a    = 0;
    m_err  = 0;
    m_disp = 0;
  endtask

  task automatic model_err();
    if (m_err < 65535) m_err++;
  endtask

  // Applies one clock edge worth of host/core activity to the reference.
  task automatic model_step();
    bit   can_accept;
    msg_t m;
    if (RST) return;
    can_accept = (mq.size() < DEPTH);
    if (mq.size() > 0) begin
      if ((mq[0].kind == 1'b0 && bus.say__RDY) || (mq[0].kind == 1'b1 && bus.say2__RDY)) begin
        void'(mq.pop_front());
        m_disp++;
      end
    end
    if (bus.EN_requests_enq && can_accept) begin
      if (m_pend && bus.requests_enq_methodNumber == 16'd1) begin
        m.kind = 1'b1; m.a = m_a; m.b = bus.requests_enq_v;
        mq.push_back(m);
        m_pend = 0;
      end else begin
        if (m_pend) begin
          model_err();
          m_pend = 0;
        end
        if (bus.requests_enq_methodNumber == 16'd0) begin
          m.kind = 1'b0; m.a = bus.requests_enq_v; m.b = 0;
          mq.push_back(m);
        end else if (bus.requests_enq_methodNumber == 16'd1) begin
          m_pend = 1;
          m_a    = bus.requests_enq_v;
        end else begin
          model_err();
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic drive(input bit en, input bit [15:0] m, input bit [31:0] v);
    bus.EN_requests_enq           = en;
    bus.requests_enq_methodNumber = m;
    bus.requests_enq_v            = v;
  endtask

  task automatic test_reset();
    drive(0, 0, 0);
    bus.say__RDY = 1; bus.say2__RDY = 1;
    bus.messageSize_size_methodNumber = 16'd0;
    #1;
    checks++; if (bus.RDY_requests_enq !== 1'b0) begin errors++; $display("FAIL rst_rdy_enq: got %b want 0", bus.RDY_requests_enq); end
    checks++; if (bus.RDY_messageSize_size !== 1'b0) begin errors++; $display("FAIL rst_rdy_size: got %b want 0", bus.RDY_messageSize_size); end
    checks++; if (bus.messageSize_size !== 16'd0) begin errors++; $display("FAIL rst_size: got %0d want 0", bus.messageSize_size); end
    checks++; if (bus.say__ENA !== 1'b0 || bus.say2__ENA !== 1'b0) begin errors++; $display("FAIL rst_ena: got %b%b want 00", bus.say__ENA, bus.say2__ENA); end
    checks++; if (bus.err_count !== 16'd0) begin errors++; $display("FAIL rst_err: got %0d want 0", bus.err_count); end
    @(negedge CLK);
    RST = 0;
    model_reset();
    #1;
    checks++; if (bus.RDY_requests_enq !== 1'b1) begin errors++; $display("FAIL post_rst_rdy_enq: got %b want 1", bus.RDY_requests_enq); end
    checks++; if (bus.RDY_messageSize_size !== 1'b1) begin errors++; $display("FAIL post_rst_rdy_size: got %b want 1", bus.RDY_messageSize_size); end
`ifdef ECHO_REQ_STATS_EN
    checks++; if (dispatch_count !== 32'd0) begin errors++; $display("FAIL rst_disp_cnt: got %0d want 0", dispatch_count); end
`endif
    tick();
  endtask

  task automatic test_say();
    bus.say__RDY = 1;
    drive(1, 16'd0, 32'hDEADBEEF);
    #1;
    checks++; if (bus.say__ENA !== 1'b0) begin errors++; $display("FAIL say_early: got %b want 0", bus.say__ENA); end
    tick();
    drive(0, 0, 0);
    #1;
    checks++; if (bus.say__ENA !== 1'b1) begin errors++; $display("FAIL say_ena: got %b want 1", bus.say__ENA); end
    checks++; if (bus.say_v !== 32'hDEADBEEF) begin errors++; $display("FAIL say_v: got %h want deadbeef", bus.say_v); end
    tick();
    #1;
    checks++; if (bus.say__ENA !== 1'b0) begin errors++; $display("FAIL say_empty: got %b want 0", bus.say__ENA); end
  endtask

  task automatic test_say2();
    bus.say2__RDY = 1;
    drive(1, 16'd1, 32'h1111);
    tick();
    drive(1, 16'd1, 32'h2222);
    #1;
    checks++; if (bus.say2__ENA !== 1'b0) begin errors++; $display("FAIL say2_early: got %b want 0", bus.say2__ENA); end
    tick();
    drive(0, 0, 0);
    #1;
    checks++; if (bus.say2__ENA !== 1'b1) begin errors++; $display("FAIL say2_ena: got %b want 1", bus.say2__ENA); end
    checks++; if (bus.say2_a !== 32'h1111 || bus.say2_b !== 32'h2222) begin errors++; $display("FAIL say2_args: got %h/%h want 00001111/00002222", bus.say2_a, bus.say2_b); end
    checks++; if (bus.say__ENA !== 1'b0) begin errors++; $display("FAIL say2_no_say: got %b want 0", bus.say__ENA); end
    tick();
    #1;
    checks++; if (bus.say2__ENA !== 1'b0) begin errors++; $display("FAIL say2_single: got %b want 0", bus.say2__ENA); end
  endtask

  task automatic test_backpressure();
    bus.say__RDY = 0;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 16'd0, 32'(i));
      tick();
    end
    drive(0, 0, 0);
    #1;
    checks++; if (bus.RDY_requests_enq !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", bus.RDY_requests_enq); end
    checks++; if (bus.say__ENA !== 1'b0) begin errors++; $display("FAIL bp_stall: got %b want 0", bus.say__ENA); end
    bus.say__RDY = 1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (bus.say__ENA !== 1'b1 || bus.say_v !== 32'(i)) begin errors++; $display("FAIL bp_order%0d: got ena=%b v=%0d want ena=1 v=%0d", i, bus.say__ENA, bus.say_v, i); end
      tick();
      if (i == 1) begin
        #1;
        checks++; if (bus.RDY_requests_enq !== 1'b1) begin errors++; $display("FAIL bp_rdy_back: got %b want 1", bus.RDY_requests_enq); end
      end
    end
    #1;
    checks++; if (bus.say__ENA !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", bus.say__ENA); end
  endtask

  task automatic test_errors();
    bus.say__RDY = 1; bus.say2__RDY = 1;
    drive(1, 16'd7, 32'h77);
    tick();
    drive(0, 0, 0);
    #1;
    checks++; if (bus.err_count !== 16'd1) begin errors++; $display("FAIL err_drop: got %0d want 1", bus.err_count); end
    checks++; if (bus.say__ENA !== 1'b0 || bus.say2__ENA !== 1'b0) begin errors++; $display("FAIL err_no_disp: got %b%b want 00", bus.say__ENA, bus.say2__ENA); end
    drive(1, 16'd1, 32'd5);
    tick();
    drive(1, 16'd0, 32'd9);
    tick();
    drive(0, 0, 0);
    #1;
    checks++; if (bus.err_count !== 16'd2) begin errors++; $display("FAIL err_abort: got %0d want 2", bus.err_count); end
    checks++; if (bus.say__ENA !== 1'b1 || bus.say_v !== 32'd9) begin errors++; $display("FAIL err_say9: got ena=%b v=%0d want ena=1 v=9", bus.say__ENA, bus.say_v); end
    checks++; if (bus.say2__ENA !== 1'b0) begin errors++; $display("FAIL err_no_say2: got %b want 0", bus.say2__ENA); end
    tick();
    // Assembler must be idle again: a fresh say2 pair completes normally.
    drive(1, 16'd1, 32'hA);
    tick();
    drive(1, 16'd1, 32'hB);
    tick();
    drive(0, 0, 0);
    #1;
    checks++; if (bus.say2__ENA !== 1'b1 || bus.say2_a !== 32'hA || bus.say2_b !== 32'hB) begin errors++; $display("FAIL err_idle_again: got ena=%b a=%h b=%h want 1/a/b", bus.say2__ENA, bus.say2_a, bus.say2_b); end
    checks++; if (bus.err_count !== 16'd2) begin errors++; $display("FAIL err_stable: got %0d want 2", bus.err_count); end
    tick();
  endtask

  task automatic test_msg_size();
    bit [15:0] q [3];
    bit [15:0] e [3];
    q[0] = 16'd0; q[1] = 16'd1; q[2] = 16'd3;
    e[0] = 16'd32; e[1] = 16'd64; e[2] = 16'd0;
    for (int i = 0; i < 3; i++) begin
      bus.messageSize_size_methodNumber = q[i];
      #1;
      checks++; if (bus.messageSize_size !== e[i]) begin errors++; $display("FAIL msg_size%0d: got %0d want %0d", q[i], bus.messageSize_size, e[i]); end
    end
    checks++; if (bus.RDY_messageSize_size !== 1'b1) begin errors++; $display("FAIL msg_size_rdy: got %b want 1", bus.RDY_messageSize_size); end
  endtask

  task automatic test_async_reset();
    bus.say__RDY = 0;
    drive(1, 16'd0, 32'd1);
    tick();
    drive(1, 16'd0, 32'd2);
    tick();
    drive(0, 0, 0);
    bus.say__RDY = 1;
    #1;
    checks++; if (bus.say__ENA !== 1'b1) begin errors++; $display("FAIL ar_pre: got %b want 1", bus.say__ENA); end
    #1;
    RST = 1;
    #1;
    checks++; if (bus.say__ENA !== 1'b0 || bus.say2__ENA !== 1'b0) begin errors++; $display("FAIL ar_ena_drop: got %b%b want 00", bus.say__ENA, bus.say2__ENA); end
    checks++; if (bus.RDY_requests_enq !== 1'b0) begin errors++; $display("FAIL ar_rdy_drop: got %b want 0", bus.RDY_requests_enq); end
    @(negedge CLK);
    RST = 0;
    model_reset();
    #1;
    checks++; if (bus.say__ENA !== 1'b0) begin errors++; $display("FAIL ar_no_disp: got %b want 0", bus.say__ENA); end
    checks++; if (bus.err_count !== 16'd0) begin errors++; $display("FAIL ar_err: got %0d want 0", bus.err_count); end
    checks++; if (bus.RDY_requests_enq !== 1'b1) begin errors++; $display("FAIL ar_rdy: got %b want 1", bus.RDY_requests_enq); end
    tick();
    #1;
    checks++; if (bus.say__ENA !== 1'b0) begin errors++; $display("FAIL ar_still_empty: got %b want 0", bus.say__ENA); end
  endtask

  task automatic test_random();
    bit        exp_say, exp_say2;
    bit [15:0] m, qm, exp_size;
    int        r;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      m = 16'd0;
      else if (r < 8) m = 16'd1;
      else            m = 16'($urandom_range(2, 65535));
      drive((mq.size() < DEPTH) && ($urandom_range(0, 2) != 0), m, $urandom);
      bus.say__RDY  = ($urandom_range(0, 3) != 0);
      bus.say2__RDY = ($urandom_range(0, 3) != 0);
      qm = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      bus.messageSize_size_methodNumber = qm;
      exp_size = (qm == 16'd0) ? 16'd32 : (qm == 16'd1) ? 16'd64 : 16'd0;
      exp_say  = (mq.size() > 0) && (mq[0].kind == 1'b0) && bus.say__RDY;
      exp_say2 = (mq.size() > 0) && (mq[0].kind == 1'b1) && bus.say2__RDY;
      #1;
      checks++; if (bus.say__ENA !== exp_say) begin errors++; $display("FAIL rnd_say_ena c%0d: got %b want %b", c, bus.say__ENA, exp_say); end
      checks++; if (bus.say2__ENA !== exp_say2) begin errors++; $display("FAIL rnd_say2_ena c%0d: got %b want %b", c, bus.say2__ENA, exp_say2); end
      if (exp_say) begin
        checks++; if (bus.say_v !== mq[0].a) begin errors++; $display("FAIL rnd_say_v c%0d: got %h want %h", c, bus.say_v, mq[0].a); end
      end
      if (exp_say2) begin
        checks++; if (bus.say2_a !== mq[0].a || bus.say2_b !== mq[0].b) begin errors++; $display("FAIL rnd_say2_args c%0d: got %h/%h want %h/%h", c, bus.say2_a, bus.say2_b, mq[0].a, mq[0].b); end
      end
      checks++; if (bus.RDY_requests_enq !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_rdy c%0d: got %b want %b", c, bus.RDY_requests_enq, mq.size() < DEPTH); end
      checks++; if (bus.err_count !== 16'(m_err)) begin errors++; $display("FAIL rnd_err c%0d: got %0d want %0d", c, bus.err_count, m_err); end
      checks++; if (bus.messageSize_size !== exp_size) begin errors++; $display("FAIL rnd_size c%0d: got %0d want %0d", c, bus.messageSize_size, exp_size); end
      tick();
    end
`ifdef ECHO_REQ_STATS_EN
    #1;
    checks++; if (dispatch_count !== 32'(m_disp)) begin errors++; $display("FAIL rnd_disp_cnt: got %0d want %0d", dispatch_count, m_disp); end
`endif
  endtask

  initial begin
    test_reset();
    test_say();
    test_say2();
    test_backpressure();
    test_errors();
    test_msg_size();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/echo_request_input.md
Name: echo_request_input

Overview:
- Host-to-core direction of the Echo portal. It is the counterpart of the indication-output block, which serialises core indications for the host.
- Accepts 32-bit request words written by the host, each tagged with a method number.
- Assembles complete request messages, buffers them in a small FIFO, and dispatches each message to the Echo core with an ENA/RDY handshake.
- Answers message-size queries for request methods.

Parameters:
- DEPTH, 4, number of assembled-request FIFO entries; power of 2, minimum 2.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- CLK  input  1  clock.
- RST  input  1  reset; asynchronous, active-high.
- RDY_requests_enq  output  1  request word can be accepted.
- EN_requests_enq  input  1  host writes a request word this cycle.
- requests_enq_methodNumber  input  16  method tag of the word.
- requests_enq_v  input  32  word data.
- RDY_messageSize_size  output  1  always 1 when out of reset.
- messageSize_size_methodNumber  input  16  method being queried.
- messageSize_size  output  16  payload size in bits for the queried method.
- say__ENA  output  1  dispatch say(v) to the core.
- say_v  output  32  say argument.
- say__RDY  input  1  core can accept say.
- say2__ENA  output  1  dispatch say2(a,b) to the core.
- say2_a  output  32  first say2 argument.
- say2_b  output  32  second say2 argument.
- say2__RDY  input  1  core can accept say2.
- err_count  output  16  saturating count of dropped or aborted words.

Behaviour:
- Methods: 0 = say, 1 word. 1 = say2, 2 words, a first then b. Any other method number is invalid.
- messageSize_size is combinational: 32 for method 0, 64 for method 1, 0 otherwise. RDY_messageSize_size = !RST.
- Enqueue handshake: RDY_requests_enq = !full. The host asserts EN_requests_enq only while RDY is high. A word is accepted on the rising clock edge when EN_requests_enq=1.
- Assembler FSM states: IDLE and WAIT_B.
- IDLE with method 0: push {kind=0, a=v, b=0}; stay in IDLE.
- IDLE with method 1: latch a; go to WAIT_B. No push.
- IDLE with invalid method: drop the word; err_count++.
- WAIT_B with method 1: push {kind=1, a=latched a, b=v}; go to IDLE.
- WAIT_B with any other method: the partial say2 is aborted and err_count++. The new word is then processed exactly as in IDLE during the same cycle, and the FSM moves to that path's next state.
- FIFO: DEPTH entries, 65 bits each (kind, a, b). Read and write pointers are AW+1 bits wide. full and empty are derived from the pointers.
- Simultaneous push and pop is allowed and leaves the count unchanged.
- Because RDY gates on full, no push can happen while the FIFO is full, even if a pop happens in the same cycle.
- Dispatch is combinational from the FIFO head:
  - say__ENA = !empty && kind==0 && say__RDY.
  - say2__ENA = !empty && kind==1 && say2__RDY.
  - Pop on either ENA.
  - say_v, say2_a and say2_b always show the head entry's fields.
  - Strictly in order: a head blocked on its RDY stalls all later entries.
- Latency: a say word written in cycle N can be dispatched in cycle N+1 at the earliest. For say2, the earliest dispatch is the cycle after the b word is written.
- err_count saturates at 16'hFFFF.
- Reset: pointers are 0 and the FSM is IDLE; the latched a and err_count are 0; all ENA outputs are 0, RDY_requests_enq is 0 and messageSize_size is 0.
- Reset asserted mid-operation discards all buffered and partial messages immediately. Outputs take their reset values asynchronously.

Optional Feature:
- Macro: ECHO_REQ_STATS_EN.
- When defined: adds output port dispatch_count, 32 bits, reset to 0. It increments on each cycle where say__ENA or say2__ENA is high, and wraps modulo 2^32.
- When undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package echo_portal_pkg holds:
  - the method number constants METHOD_SAY=0 and METHOD_SAY2=1;
  - the size constants SAY_BITS=32 and SAY2_BITS=64;
  - the request-entry struct type {kind, a, b};
  - the assembler state enum.
- One sub-module: echo_req_fifo, a generic DEPTH×width synchronous FIFO with async active-high reset and full/empty outputs.
- The assembler FSM, dispatch logic and error counter stay in the top module.

Test Plan:
- Reset, then write method 0 with v=32'hDEADBEEF while say__RDY=1 → say__ENA=1 one cycle later with say_v=32'hDEADBEEF; FIFO then empty.
- Write method 1 with 32'h1111, then method 1 with 32'h2222, while say2__RDY=1 → one say2__ENA pulse with a=32'h1111 and b=32'h2222; no say__ENA.
- Hold say__RDY=0 and write 4 say words (1..4) → RDY_requests_enq=0 after the 4th. Then raise say__RDY → dispatches 1, 2, 3, 4 in order on consecutive cycles; RDY returns to 1 after the first pop.
- Write method 7 → word dropped and err_count=1. Then write method 1 (a=5) followed by method 0 (v=9) → err_count=2, only say(9) is dispatched, FSM back in IDLE.
- Query messageSize with method numbers 0, 1 and 3 → 32, 64 and 0.
- Buffer 2 entries, then assert RST asynchronously mid-cycle → ENA outputs drop immediately. After release: no dispatch, err_count=0, RDY_requests_enq=1.
